// File: rtl/regfile_write_queue.sv
// In-order writeback queue in front of the register-file write port; absorbs wr_stall cycles.
// Optional read-port bypass of pending writes is enabled by defining REGFILE_WQ_BYPASS_EN.
module regfile_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     wr_stall,
  output logic                     write_enable,
  output logic [AW-1:0]            address_d,
  output logic [DW-1:0]            data_dval,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [AW-1:0]            address_s1,
  input  logic [AW-1:0]            address_s2,
  output logic                     byp_s1_hit,
  output logic [DW-1:0]            byp_s1_data,
  output logic                     byp_s2_hit,
  output logic [DW-1:0]            byp_s2_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a request transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on count, never on in_valid or wr_stall.

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty    = (count == '0);
  assign in_ready = (count != CW'(DEPTH));
  // Writes to $zero complete the handshake but are dropped.
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign pop      = write_enable;

  always_comb begin
    write_enable = 1'b0;
    address_d    = '0;
    data_dval    = '0;
    if (!reset && !empty) begin
      write_enable = !wr_stall;
      address_d    = mem_addr[rd_ptr];
      data_dval    = mem_data[rd_ptr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_data[wr_ptr] <= in_data;
    end
  end

`ifdef REGFILE_WQ_BYPASS_EN
  // Walk from head to tail so the youngest matching entry wins.
  always_comb begin
    byp_s1_hit  = 1'b0;
    byp_s1_data = '0;
    byp_s2_hit  = 1'b0;
    byp_s2_data = '0;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) < count) begin
          if (address_s1 != '0 && mem_addr[rd_ptr + PW'(i)] == address_s1) begin
            byp_s1_hit  = 1'b1;
            byp_s1_data = mem_data[rd_ptr + PW'(i)];
          end
          if (address_s2 != '0 && mem_addr[rd_ptr + PW'(i)] == address_s2) begin
            byp_s2_hit  = 1'b1;
            byp_s2_data = mem_data[rd_ptr + PW'(i)];
          end
        end
      end
    end
  end
`else
  logic unused_read_addr;
  assign unused_read_addr = ^{address_s1, address_s2};
  assign byp_s1_hit  = 1'b0;
  assign byp_s1_data = '0;
  assign byp_s2_hit  = 1'b0;
  assign byp_s2_data = '0;
`endif

endmodule
